rom_port_arbiter: RTL and testbench

//  Shares the single synchronous-read program ROM port (8-bit ADDR in, registered DATA out,
//  1-cycle read) between two requesters: A = processor instruction fetch, B = secondary

---
 rtl/rom_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
//
// Lets two requesters share the one synchronous-read program ROM port.
//   A = processor instruction fetch
//   B = secondary reader (debug / DMA table fetch)
//
// One read is granted per cycle. The granted address is registered onto the
// ROM address bus. A 2-deep tag pipe follows each read until its data comes
// back, and the data is then returned to the owner with a one-cycle VALID
// pulse. Read latency is fixed at 2 cycles and a new read can start every
// cycle.
//
// Timeline of one read:
//   cycle t   : REQ_x && GNT_x, rom_addr <= ADDR_x at the end of t
//   cycle t+1 : the ROM samples rom_addr at the end of t+1
//   cycle t+2 : VALID_x = 1, RDATA_x = ROM_DATA
//
// Parameters
//   ADDR_W    ROM address width
//   DATA_W    ROM data width
//   FIXED_PRI 0 = round-robin between A and B; 1 = A has fixed priority
//   MAX_WAIT  Used only when FIXED_PRI=1. Number of blocked B cycles before
//             B is forced through (1..15).
//
// Ports
//   clk_i       system clock; all state changes on the rising edge
//   resetn_i    asynchronous reset, active low
//   req_a_i     A read request. A holds it, with addr_a_i stable, until gnt_a_o.
//   addr_a_i    A read address
//   gnt_a_o     A request accepted this cycle (combinational)
//   valid_a_o   rdata_a_o carries A's read data this cycle
//   rdata_a_o   ROM data while valid_a_o is high, otherwise 0
//   req_b_i, addr_b_i, gnt_b_o, valid_b_o, rdata_b_o
//               the same set of signals for requester B
//   rom_addr_o  registered address to the ROM
//   rom_data_i  data from the ROM, valid 1 cycle after it samples rom_addr_o
// ---------------------------------------------------------------------------
module rom_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int FIXED_PRI = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,

    input  logic              req_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    output logic              gnt_a_o,
    output logic              valid_a_o,
    output logic [DATA_W-1:0] rdata_a_o,

    input  logic              req_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              gnt_b_o,
    output logic              valid_b_o,
    output logic [DATA_W-1:0] rdata_b_o,

    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    // Round-robin pointer states
    //   state | meaning
    //   PTR_A | A wins the next A/B contention
    //   PTR_B | B wins the next A/B contention
    // The pointer moves only when a grant is issued. It then points at the
    // side that was not served.
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int                WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam bit                FIXED    = (FIXED_PRI != 0);

    ptr_e              ptr_q, ptr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    // Tag pipe: stage0 is loaded when a grant is issued. stage1 lines up
    // with the ROM data coming back.
    logic s0_vld_q, s0_vld_d;
    logic s0_id_q,  s0_id_d;
    logic s1_vld_q;
    logic s1_id_q;

    logic gnt_a;
    logic gnt_b;
    logic force_b;

    // Grant decision. While reset is held, no grant is issued, even though
    // the state registers already show their idle values.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        force_b = FIXED && req_b_i && (wait_q == WAIT_MAX);

        if (resetn_i) begin
            if (FIXED) begin
                if (force_b) begin
                    gnt_b = 1'b1;
                end else if (req_a_i) begin
                    gnt_a = 1'b1;
                end else if (req_b_i) begin
                    gnt_b = 1'b1;
                end
            end else begin
                if (req_a_i && req_b_i) begin
                    if (ptr_q == PTR_A) begin
                        gnt_a = 1'b1;
                    end else begin
                        gnt_b = 1'b1;
                    end
                end else begin
                    gnt_a = req_a_i;
                    gnt_b = req_b_i;
                end
            end
        end
    end

    // Next-state logic for the pointer, the starvation counter, the ROM
    // address and tag stage0.
    always_comb begin
        ptr_d      = ptr_q;
        wait_d     = wait_q;
        rom_addr_d = rom_addr_q;
        s0_vld_d   = 1'b0;
        s0_id_d    = s0_id_q;

        if (gnt_a) begin
            ptr_d      = PTR_B;
            rom_addr_d = addr_a_i;
            s0_vld_d   = 1'b1;
            s0_id_d    = ID_A;
        end else if (gnt_b) begin
            ptr_d      = PTR_A;
            rom_addr_d = addr_b_i;
            s0_vld_d   = 1'b1;
            s0_id_d    = ID_B;
        end

        // The counter only has a job in fixed-priority mode. There it counts
        // how many cycles B has been held off, and it stops at MAX_WAIT.
        if (FIXED) begin
            if (!req_b_i || gnt_b) begin
                wait_d = '0;
            end else if (wait_q != WAIT_MAX) begin
                wait_d = wait_q + WAIT_ONE;
            end
        end else begin
            wait_d = '0;
        end
    end

    // A reset in the middle of operation clears the tag pipe, so any read
    // still in flight never produces a VALID. The requesters must reissue it.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ptr_q      <= PTR_A;
            wait_q     <= '0;
            rom_addr_q <= '0;
            s0_vld_q   <= 1'b0;
            s0_id_q    <= ID_A;
            s1_vld_q   <= 1'b0;
            s1_id_q    <= ID_A;
        end else begin
            ptr_q      <= ptr_d;
            wait_q     <= wait_d;
            rom_addr_q <= rom_addr_d;
            s0_vld_q   <= s0_vld_d;
            s0_id_q    <= s0_id_d;
            s1_vld_q   <= s0_vld_q;
            s1_id_q    <= s0_id_q;
        end
    end

    assign gnt_a_o    = gnt_a;
    assign gnt_b_o    = gnt_b;
    assign rom_addr_o = rom_addr_q;

    // stage1 holds exactly one owner id, so VALID_A and VALID_B can never
    // be high in the same cycle.
    assign valid_a_o  = s1_vld_q && (s1_id_q == ID_A);
    assign valid_b_o  = s1_vld_q && (s1_id_q == ID_B);
    assign rdata_a_o  = valid_a_o ? rom_data_i : '0;
    assign rdata_b_o  = valid_b_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    localparam int MAXW = 4;

    typedef struct {
        bit         req_a;
        logic [7:0] addr_a;
        bit         req_b;
        logic [7:0] addr_b;
        bit         gnt_a;
        bit         gnt_b;
    } vec_t;

    typedef struct {
        int         dut;
        int         due;
        bit         id;
        logic [7:0] addr;
    } ret_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic       req_a    [2];
    logic [7:0] addr_a   [2];
    logic       req_b    [2];
    logic [7:0] addr_b   [2];
    logic       gnt_a    [2];
    logic       gnt_b    [2];
    logic       valid_a  [2];
    logic       valid_b  [2];
    logic [7:0] rdata_a  [2];
    logic [7:0] rdata_b  [2];
    logic [7:0] rom_addr [2];
    logic [7:0] rom_data [2];

    logic [7:0] rom [256];

    always @(posedge clk) begin
        rom_data[0] <= rom[rom_addr[0]];
        rom_data[1] <= rom[rom_addr[1]];
    end

    rom_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRI(0), .MAX_WAIT(MAXW)) u_rr (
        .clk_i(clk), .resetn_i(resetn),
        .req_a_i(req_a[0]), .addr_a_i(addr_a[0]), .gnt_a_o(gnt_a[0]),
        .valid_a_o(valid_a[0]), .rdata_a_o(rdata_a[0]),
        .req_b_i(req_b[0]), .addr_b_i(addr_b[0]), .gnt_b_o(gnt_b[0]),
        .valid_b_o(valid_b[0]), .rdata_b_o(rdata_b[0]),
        .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0])
    );

    rom_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRI(1), .MAX_WAIT(MAXW)) u_fx (
        .clk_i(clk), .resetn_i(resetn),
        .req_a_i(req_a[1]), .addr_a_i(addr_a[1]), .gnt_a_o(gnt_a[1]),
        .valid_a_o(valid_a[1]), .rdata_a_o(rdata_a[1]),
        .req_b_i(req_b[1]), .addr_b_i(addr_b[1]), .gnt_b_o(gnt_b[1]),
        .valid_b_o(valid_b[1]), .rdata_b_o(rdata_b[1]),
        .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1])
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_prefer_b [2];
    int         m_wait     [2];
    logic [7:0] m_rom_addr [2];
    ret_t       inflight   [$];
    int         cyc = 0;
    bit         mg_a [2];
    bit         mg_b [2];
    bit         dg_a [2];
    bit         dg_b [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        for (int d = 0; d < 2; d++) begin
            m_prefer_b[d] = 1'b0;
            m_wait[d]     = 0;
            m_rom_addr[d] = 8'h00;
        end
    endtask

    // Inputs for the current cycle are already applied. This task checks
    // the cycle, advances the model and returns at the next falling edge.
    task automatic step(input string tag);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit         ga, gb, ev_a, ev_b;
            logic [7:0] ed_a, ed_b;
            string      p;
            ret_t       e;
            p  = (d == 0) ? {tag, "_rr"} : {tag, "_fx"};
            ga = 1'b0;
            gb = 1'b0;
            if (d == 0) begin
                if (req_a[d] && req_b[d]) begin
                    ga = !m_prefer_b[d];
                    gb = m_prefer_b[d];
                end else begin
                    ga = req_a[d];
                    gb = req_b[d];
                end
            end else begin
                if (req_b[d] && m_wait[d] == MAXW) gb = 1'b1;
                else if (req_a[d])                 ga = 1'b1;
                else                               gb = req_b[d];
            end
            ev_a = 1'b0; ev_b = 1'b0; ed_a = 8'h00; ed_b = 8'h00;
            foreach (inflight[i]) begin
                if (inflight[i].dut == d && inflight[i].due == cyc) begin
                    if (inflight[i].id == 1'b0) begin
                        ev_a = 1'b1;
                        ed_a = rom[inflight[i].addr];
                    end else begin
                        ev_b = 1'b1;
                        ed_b = rom[inflight[i].addr];
                    end
                end
            end
            chk({p, "_gnt_a"},    32'(gnt_a[d]),    32'(ga));
            chk({p, "_gnt_b"},    32'(gnt_b[d]),    32'(gb));
            chk({p, "_valid_a"},  32'(valid_a[d]),  32'(ev_a));
            chk({p, "_valid_b"},  32'(valid_b[d]),  32'(ev_b));
            chk({p, "_rdata_a"},  32'(rdata_a[d]),  32'(ed_a));
            chk({p, "_rdata_b"},  32'(rdata_b[d]),  32'(ed_b));
            chk({p, "_rom_addr"}, 32'(rom_addr[d]), 32'(m_rom_addr[d]));
            dg_a[d] = gnt_a[d];
            dg_b[d] = gnt_b[d];
            mg_a[d] = ga;
            mg_b[d] = gb;
            if (ga) begin
                e.dut = d; e.due = cyc + 2; e.id = 1'b0; e.addr = addr_a[d];
                inflight.push_back(e);
                m_rom_addr[d] = addr_a[d];
                m_prefer_b[d] = 1'b1;
            end else if (gb) begin
                e.dut = d; e.due = cyc + 2; e.id = 1'b1; e.addr = addr_b[d];
                inflight.push_back(e);
                m_rom_addr[d] = addr_b[d];
                m_prefer_b[d] = 1'b0;
            end
            if (d == 1) begin
                if (!req_b[d] || gb)    m_wait[d] = 0;
                else if (m_wait[d] < MAXW) m_wait[d]++;
            end
        end
        @(posedge clk);
        cyc++;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (inflight[i].due < cyc) inflight.delete(i);
        end
        @(negedge clk);
    endtask

    task automatic check_in_reset(input string tag);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rst_gnt_a"},    32'(gnt_a[d]),    32'd0);
            chk({tag, "_rst_gnt_b"},    32'(gnt_b[d]),    32'd0);
            chk({tag, "_rst_valid_a"},  32'(valid_a[d]),  32'd0);
            chk({tag, "_rst_valid_b"},  32'(valid_b[d]),  32'd0);
            chk({tag, "_rst_rdata_a"},  32'(rdata_a[d]),  32'd0);
            chk({tag, "_rst_rom_addr"}, 32'(rom_addr[d]), 32'd0);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            req_a[d] = 1'b0; req_b[d] = 1'b0;
            addr_a[d] = 8'h00; addr_b[d] = 8'h00;
        end
    endtask

    vec_t tbl [11];
    bit   exp_fx_b [6];
    bit   pa [2];
    bit   pb [2];
    logic [7:0] pad_a [2];
    logic [7:0] pad_b [2];
    int   nvalid;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 90) % 256);
        rom[8'h10] = 8'h3C;

        tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hA7, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'h35, 1'b1, 8'h36, 1'b0, 1'b1};
        exp_fx_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        idle_all();
        model_reset();

        // Reset held while A requests, then released
        req_a[0] = 1'b1; addr_a[0] = 8'h10;
        @(negedge clk);
        @(negedge clk);
        check_in_reset("t1");
        resetn = 1'b1;
        step("t1");
        chk("t1_gnt_a_after_release", 32'(dg_a[0]), 32'd1);
        req_a[0] = 1'b0;

        // A single read, with its exact timing
        chk("t2_rom_addr_t1", 32'(rom_addr[0]), 32'h10);
        chk("t2_valid_a_t1",  32'(valid_a[0]),  32'd0);
        step("t2");
        chk("t2_valid_a_t2",  32'(valid_a[0]),  32'd1);
        chk("t2_rdata_a_t2",  32'(rdata_a[0]),  32'h3C);
        step("t2");
        chk("t2_valid_a_t3",  32'(valid_a[0]),  32'd0);

        // Table of round-robin vectors
        for (int i = 0; i < 11; i++) begin
            req_a[0] = tbl[i].req_a; addr_a[0] = tbl[i].addr_a;
            req_b[0] = tbl[i].req_b; addr_b[0] = tbl[i].addr_b;
            step("tbl");
            chk($sformatf("tbl%0d_gnt_a", i), 32'(dg_a[0]), 32'(tbl[i].gnt_a));
            chk($sformatf("tbl%0d_gnt_b", i), 32'(dg_b[0]), 32'(tbl[i].gnt_b));
        end
        idle_all();
        step("tbl_drain");
        step("tbl_drain");

        // Eight back-to-back A reads with no bubbles
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            req_a[0] = (i < 8);
            addr_a[0] = 8'(i);
            step("t4");
            if (valid_a[0] === 1'b1) nvalid++;
        end
        chk("t4_valid_a_count", 32'(nvalid), 32'd8);
        idle_all();

        // Fixed priority: B is forced through after MAX_WAIT blocked cycles
        req_a[1] = 1'b1; addr_a[1] = 8'h30;
        req_b[1] = 1'b1; addr_b[1] = 8'h31;
        for (int i = 0; i < 6; i++) begin
            step("t5");
            chk($sformatf("t5_%0d_gnt_b", i), 32'(dg_b[1]), 32'(exp_fx_b[i]));
            chk($sformatf("t5_%0d_gnt_a", i), 32'(dg_a[1]), 32'(!exp_fx_b[i]));
        end
        idle_all();
        step("t5_drain");
        step("t5_drain");

        // Reset in the middle of a read
        req_a[0] = 1'b1; addr_a[0] = 8'h44;
        req_b[0] = 1'b1; addr_b[0] = 8'h45;
        step("t6");
        chk("t6_gnt_b", 32'(dg_b[0]), 32'd1);
        idle_all();
        resetn = 1'b0;
        model_reset();
        check_in_reset("t6");
        @(posedge clk);
        cyc++;
        @(negedge clk);
        resetn = 1'b1;
        step("t6");
        chk("t6_no_stale_valid_b", 32'(valid_b[0]), 32'd0);
        req_a[0] = 1'b1; addr_a[0] = 8'h46;
        req_b[0] = 1'b1; addr_b[0] = 8'h47;
        step("t6");
        chk("t6_ptr_back_to_a", 32'(dg_a[0]), 32'd1);
        idle_all();
        step("t6_drain");
        step("t6_drain");

        // Random traffic on both instances; each requester follows the handshake
        for (int d = 0; d < 2; d++) begin
            pa[d] = 1'b0; pb[d] = 1'b0; pad_a[d] = 8'h00; pad_b[d] = 8'h00;
        end
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!pa[d] && $urandom_range(0, 99) < 55) begin
                    pa[d] = 1'b1; pad_a[d] = 8'($urandom_range(0, 255));
                end
                if (!pb[d] && $urandom_range(0, 99) < 55) begin
                    pb[d] = 1'b1; pad_b[d] = 8'($urandom_range(0, 255));
                end
                req_a[d]  = pa[d];
                req_b[d]  = pb[d];
                addr_a[d] = pa[d] ? pad_a[d] : 8'($urandom_range(0, 255));
                addr_b[d] = pb[d] ? pad_b[d] : 8'($urandom_range(0, 255));
            end
            step("rnd");
            for (int d = 0; d < 2; d++) begin
                if (mg_a[d]) pa[d] = 1'b0;
                if (mg_b[d]) pb[d] = 1'b0;
            end
        end
        idle_all();
        for (int i = 0; i < 3; i++) step("end_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
